// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE core controllers.
package shake_pkg;

  localparam int KECCAK_ROUNDS = 24;
  localparam int ROUND_IDX_W   = 5;

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    PERMUTE,
    WAIT_INPUT,
    SQUEEZE
  } state_t;

endpackage

// File: rtl/round_counter.sv
// Modulo-ROUNDS round counter; sits at zero whenever no permutation is running.
module round_counter
  import shake_pkg::*;
#(
  parameter int ROUNDS = KECCAK_ROUNDS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic [ROUND_IDX_W-1:0] count,
  output logic                   last
);

  logic [ROUND_IDX_W-1:0] count_d, count_q;

  assign last  = (count_q == ROUND_IDX_W'(ROUNDS - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/permute_fsm.sv
// Absorb/permute/squeeze sequencer for the Keccak state datapath.
// Drives enables only; all data lives in the buffers and state register.
module permute_fsm
  import shake_pkg::*;
#(
  parameter int ROUNDS    = KECCAK_ROUNDS,
  parameter int OUT_BLK_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   input_buffer_ready,
  input  logic                   last_block_in_buffer,
  input  logic [OUT_BLK_W-1:0]   output_blocks,
  input  logic                   output_buffer_ready,
  output logic                   input_buffer_ready_clr,
  output logic                   absorb_enable,
  output logic                   round_enable,
  output logic [ROUND_IDX_W-1:0] round_index,
  output logic                   state_reset,
  output logic                   output_buffer_ready_wr,
  output logic                   last_output_block_wr,
  output logic                   busy
);

  state_t                 state_d, state_q;
  logic [OUT_BLK_W-1:0]   rem_d, rem_q;
  logic                   last_d, last_q;
  logic                   round_last;

  round_counter #(.ROUNDS(ROUNDS)) u_round_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (round_enable),
    .count (round_index),
    .last  (round_last)
  );

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d                = state_q;
    rem_d                  = rem_q;
    last_d                 = last_q;
    input_buffer_ready_clr = 1'b0;
    absorb_enable          = 1'b0;
    round_enable           = 1'b0;
    state_reset            = 1'b0;
    output_buffer_ready_wr = 1'b0;
    last_output_block_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (input_buffer_ready) begin
          rem_d   = (output_blocks == '0) ? OUT_BLK_W'(1) : output_blocks;
          state_d = ABSORB;
        end
      end
      ABSORB: begin
        absorb_enable          = 1'b1;
        input_buffer_ready_clr = 1'b1;
        last_d                 = last_block_in_buffer;
        state_d                = PERMUTE;
      end
      PERMUTE: begin
        round_enable = 1'b1;
        // The last message block has priority over a waiting input block.
        if (round_last) begin
          if (last_q) begin
            state_d = SQUEEZE;
          end else if (input_buffer_ready) begin
            state_d = ABSORB;
          end else begin
            state_d = WAIT_INPUT;
          end
        end
      end
      WAIT_INPUT: begin
        if (input_buffer_ready) begin
          state_d = ABSORB;
        end
      end
      SQUEEZE: begin
        if (!output_buffer_ready) begin
          output_buffer_ready_wr = 1'b1;
          last_output_block_wr   = (rem_q == OUT_BLK_W'(1));
          if (rem_q <= OUT_BLK_W'(1)) begin
            state_reset = 1'b1;
            last_d      = 1'b0;
            state_d     = IDLE;
          end else begin
            rem_d   = rem_q - 1'b1;
            state_d = PERMUTE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/permute_fsm.md
# permute_fsm

Second-stage controller of the SHAKE core. Sequences the Keccak-f[1600] state datapath between the input SIPO buffer (filled by the load stage) and the output buffer (drained by the output stage). For each message it absorbs every rate block, runs ROUNDS round iterations per block, then squeezes the requested number of output blocks, re-permuting between them. It drives the datapath through enables only and holds no data itself.

## Interface
- ROUNDS, 24: Keccak-f rounds per permutation.
- OUT_BLK_W, 16: width of the output-block count.
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous and active-high.
- input_buffer_ready  in  1  handshake flag. Input buffer holds a full block.
- last_block_in_buffer  in  1  the block in the input buffer is the message's last block.
- output_blocks  in  OUT_BLK_W  number of rate blocks to squeeze. Sampled when a message starts. 0 is treated as 1.
- output_buffer_ready  in  1  handshake flag. Output buffer is still occupied.
- input_buffer_ready_clr  out  1  pulse. Clears the input handshake flag (block consumed).
- absorb_enable  out  1  XOR the input buffer into the rate part of the state.
- round_enable  out  1  apply one round to the state.
- round_index  out  5  round-constant index, 0..ROUNDS-1.
- state_reset  out  1  zero the state register.
- output_buffer_ready_wr  out  1  pulse. Copies the state rate part into the output buffer and sets its flag.
- last_output_block_wr  out  1  qualifies output_buffer_ready_wr: this is the final output block.
- busy  out  1  high when state ≠ IDLE.

## Operation
- Registered state: FSM state, round counter, remaining-block counter rem (OUT_BLK_W), last_r.
- **IDLE**
  - Outputs 0.
  - If input_buffer_ready: load rem ← max(output_blocks, 1) and go to ABSORB.
- **ABSORB** (1 cycle)
  - Assert absorb_enable and input_buffer_ready_clr.
  - Capture last_r ← last_block_in_buffer.
  - Go to PERMUTE with the round counter at 0.
- **PERMUTE** (ROUNDS cycles)
  - Assert round_enable. round_index = counter; the counter increments each cycle.
  - On the counter = ROUNDS-1 cycle, the counter wraps to 0 and the next state is chosen by priority:
    - last_r = 1: go to SQUEEZE.
    - else input_buffer_ready = 1: go to ABSORB (back-to-back, no bubble).
    - else: go to WAIT_INPUT.
- **WAIT_INPUT**
  - Outputs 0.
  - Go to ABSORB when input_buffer_ready = 1.
- **SQUEEZE**
  - While output_buffer_ready = 1: stall with outputs 0.
  - Otherwise assert output_buffer_ready_wr, and set last_output_block_wr = (rem == 1). Then:
    - rem == 1: assert state_reset, clear last_r, go to IDLE.
    - else: rem ← rem-1, go to PERMUTE. No absorb occurs.
- **Illegal state encoding:** go to IDLE.
- **Reset values:** all outputs 0, round_index 0, rem 0, last_r 0, state IDLE.
- **Reset asserted mid-operation:** everything returns to IDLE asynchronously. state_reset is not asserted by reset itself; the state register has its own reset.

## Timing
- Single-block message, output buffer free: input_buffer_ready seen in IDLE at cycle 0.
  - ABSORB at cycle 1.
  - PERMUTE at cycles 2..ROUNDS+1.
  - SQUEEZE write at cycle ROUNDS+2.
  - IDLE at cycle ROUNDS+3.
- Throughput: ROUNDS+1 cycles per absorbed block when inputs arrive back-to-back, and ROUNDS+1 cycles per extra output block.
- input_buffer_ready_clr is a single-cycle pulse. The flag drops on the next edge, so the load stage may refill the buffer while PERMUTE runs.
- input_buffer_ready is ignored in every state except IDLE, WAIT_INPUT and the final PERMUTE cycle.
- output_buffer_ready_wr fires at most once per SQUEEZE visit. The output flag is sampled in the same cycle, with no lookahead.
- output_blocks is ignored outside the IDLE→ABSORB transition. Changes to it mid-message have no effect.
- rem never wraps: it is only decremented when rem ≥ 2.

## Structure
- Put in shake_pkg:
  - The state_t enum (IDLE, ABSORB, PERMUTE, WAIT_INPUT, SQUEEZE).
  - KECCAK_ROUNDS = 24.
  - The round-index width constant.
- One sub-module, round_counter:
  - Ports: clk, rst, en, count[4:0], last.
  - MOD-ROUNDS counter; wraps to 0 when en is high and count is ROUNDS-1.
  - last = (count == ROUNDS-1).

## Test plan
- One block, last = 1, output_blocks = 1, output buffer free:
  - clr and absorb at cycle 1.
  - round_enable for cycles 2–25, with round_index 0..23.
  - Write with last_output_block_wr = 1 plus state_reset at cycle 26.
  - busy low at cycle 27.
- Three blocks back-to-back (flag re-set during each PERMUTE), output_blocks = 1:
  - ABSORB at cycles 1, 26, 51.
  - A single write at cycle 76.
- Second block arrives 10 cycles late:
  - WAIT_INPUT is held for 10 cycles, with every output 0.
  - ABSORB follows the cycle after the flag rises.
- output_blocks = 3, output_buffer_ready held high for 5 cycles before each write:
  - Three writes, with last_output_block_wr only on the third.
  - Exactly 24 round_enable cycles between consecutive writes.
  - No absorb_enable during squeeze.
- output_blocks = 0: exactly one write, flagged last.
- rst pulsed at round_index 12:
  - All outputs 0 and busy low immediately.
  - A subsequent one-block message behaves exactly like the first test.
